// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd: sequential double-dabble binary-to-BCD converter.
// One operand bit is consumed per clock. A start/busy/done handshake frames
// each conversion, and an overflow flag reports magnitudes that do not fit
// in DIGITS decimal digits.
// Optional feature: define BIN2BCD_SIGNED_EN to treat bin as two's complement.
// The converter then reports the sign on neg and converts the magnitude.
module seq_bin2bcd #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf,
  output logic                neg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   sreg, sreg_nxt;
  logic [BIN_W-1:0]   mag;
  logic [BCD_W-1:0]   acc, adj, acc_nxt;
  logic               ovf_st, ovf_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               last;

  // The counter reaches zero on the final shift of the conversion.
  assign last = (cnt == '0);
  assign busy = (state == SHIFT);

`ifdef BIN2BCD_SIGNED_EN
  logic sign_lat;
  // The negation is done at BIN_W bits, so -2**(BIN_W-1) maps to its exact magnitude.
  assign mag = bin[BIN_W-1] ? -bin : bin;
`else
  assign mag = bin;
  assign neg = 1'b0;
`endif

  // FSM next state: leave IDLE on start, and return to IDLE after the last shift.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One double-dabble step. All digits are adjusted from pre-shift values,
  // then {carry, digits, operand} shifts left by one bit.
  always_comb begin
    adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    acc_nxt  = {adj[BCD_W-2:0], sreg[BIN_W-1]};
    ovf_nxt  = ovf_st | adj[BCD_W-1];
    sreg_nxt = {sreg[BIN_W-2:0], 1'b0};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: load the operand on accept, shift while busy, and publish the result on the final shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg   <= '0;
      acc    <= '0;
      ovf_st <= 1'b0;
      cnt    <= '0;
      bcd    <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign_lat <= 1'b0;
      neg      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg   <= mag;
            acc    <= '0;
            ovf_st <= 1'b0;
            cnt    <= CNT_W'(BIN_W - 1);
`ifdef BIN2BCD_SIGNED_EN
            sign_lat <= bin[BIN_W-1];
`endif
          end
        end
        SHIFT: begin
          sreg   <= sreg_nxt;
          acc    <= acc_nxt;
          ovf_st <= ovf_nxt;
          if (last) begin
            bcd  <= acc_nxt;
            ovf  <= ovf_nxt;
            done <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
            neg  <= sign_lat;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
